// File: rtl/rb_interp_scheduler.sv
`timescale 1ns/1ps
// Round-robin sequencer sharing one fixed-latency R/B interpolation datapath between the
// R-plane and B-plane request streams, with in-order result buffering and credit-based issue.
module rb_interp_scheduler #(
  parameter int unsigned gradBitWidth  = 8,
  parameter int unsigned pixelBitWidth = 12,
  parameter int unsigned OPW           = pixelBitWidth + 2*gradBitWidth + 2*(pixelBitWidth+2),
  parameter int unsigned TAG_W         = 16,
  parameter int unsigned DP_LATENCY    = 2,
  parameter int unsigned OUT_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     r_valid,
  output logic                     r_ready,
  input  logic [OPW-1:0]           r_operands,
  input  logic [TAG_W-1:0]         r_tag,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [OPW-1:0]           b_operands,
  input  logic [TAG_W-1:0]         b_tag,
  output logic [OPW-1:0]           dp_operands,
  input  logic [pixelBitWidth-1:0] dp_rb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [pixelBitWidth-1:0] out_rb,
  output logic                     out_plane,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int unsigned NSTAGE = DP_LATENCY + 1;
  localparam int unsigned PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUM_W  = $clog2(OUT_DEPTH + NSTAGE + 1) + 1;
  localparam int unsigned ENT_W  = pixelBitWidth + 1 + TAG_W;

  logic [NSTAGE-1:0] stg_v;
  logic [NSTAGE-1:0] stg_plane;
  logic [TAG_W-1:0]  stg_tag [NSTAGE];
  logic              prio;

  logic [ENT_W-1:0]  fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic [SUM_W-1:0]  inflight;
  logic [SUM_W-1:0]  credit_used;
  logic              can_issue;
  logic              grant_r;
  logic              grant_b;
  logic              push;
  logic              pop;
  logic              full;

  // Results still owed by the datapath pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(NSTAGE); i++) begin
      inflight = inflight + SUM_W'(stg_v[i]);
    end
  end

  assign pop         = out_valid & out_ready;
  assign push        = stg_v[NSTAGE-1];
  assign full        = (fifo_count == CNT_W'(OUT_DEPTH));
  assign credit_used = inflight + SUM_W'(fifo_count) - SUM_W'(pop);
  // Grants are gated by rst so the ready outputs read low while reset is held.
  assign can_issue   = rst & enable & (credit_used < SUM_W'(OUT_DEPTH));
  assign grant_r     = can_issue & r_valid & (~prio | ~b_valid);
  assign grant_b     = can_issue & b_valid & (prio | ~r_valid);
  assign r_ready     = grant_r;
  assign b_ready     = grant_b;

  // Operand register and round-robin pointer; both hold when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_operands <= '0;
      prio        <= 1'b0;
    end else if (grant_r) begin
      dp_operands <= r_operands;
      prio        <= 1'b1;
    end else if (grant_b) begin
      dp_operands <= b_operands;
      prio        <= 1'b0;
    end
  end

  // Plane/tag tracker aligned with the datapath latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_v     <= '0;
      stg_plane <= '0;
      for (int i = 0; i < int'(NSTAGE); i++) begin
        stg_tag[i] <= '0;
      end
    end else begin
      stg_v      <= {stg_v[NSTAGE-2:0], grant_r | grant_b};
      stg_plane  <= {stg_plane[NSTAGE-2:0], grant_b};
      stg_tag[0] <= grant_b ? b_tag : r_tag;
      for (int i = 1; i < int'(NSTAGE); i++) begin
        stg_tag[i] <= stg_tag[i-1];
      end
    end
  end

  // Output FIFO; push and pop may coincide at any occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {dp_rb, stg_plane[NSTAGE-1], stg_tag[NSTAGE-1]};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  assign out_valid                  = (fifo_count != '0);
  assign {out_rb, out_plane, out_tag} = fifo_mem[rd_ptr];

  // The credit check must make a lossy push impossible.
  assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: tb/tb_rb_interp_scheduler.sv
`timescale 1ns/1ps
// Randomized self-checking bench: a timestamped in-order queue model predicts grants,
// credit throttling and every delivered result for depth-4 and depth-2 instances.
module tb_rb_interp_scheduler;

  localparam int unsigned PW    = 12;
  localparam int unsigned GW    = 8;
  localparam int unsigned OPW   = PW + 2*GW + 2*(PW+2);
  localparam int unsigned TAG_W = 16;
  localparam int unsigned DPL   = 2;

  typedef struct {
    logic [PW-1:0]    rb;
    logic             plane;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             enable     [2];
  logic             r_valid    [2];
  logic             r_ready    [2];
  logic [OPW-1:0]   r_operands [2];
  logic [TAG_W-1:0] r_tag      [2];
  logic             b_valid    [2];
  logic             b_ready    [2];
  logic [OPW-1:0]   b_operands [2];
  logic [TAG_W-1:0] b_tag      [2];
  logic [OPW-1:0]   dp_operands[2];
  logic [PW-1:0]    dp_s1      [2];
  logic [PW-1:0]    dp_rb      [2];
  logic             out_valid  [2];
  logic             out_ready  [2];
  logic [PW-1:0]    out_rb     [2];
  logic             out_plane  [2];
  logic [TAG_W-1:0] out_tag    [2];

  rb_interp_scheduler #(.gradBitWidth(GW), .pixelBitWidth(PW), .OPW(OPW), .TAG_W(TAG_W),
                        .DP_LATENCY(DPL), .OUT_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable[0]),
    .r_valid(r_valid[0]), .r_ready(r_ready[0]), .r_operands(r_operands[0]), .r_tag(r_tag[0]),
    .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_operands(b_operands[0]), .b_tag(b_tag[0]),
    .dp_operands(dp_operands[0]), .dp_rb(dp_rb[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_rb(out_rb[0]),
    .out_plane(out_plane[0]), .out_tag(out_tag[0]));

  rb_interp_scheduler #(.gradBitWidth(GW), .pixelBitWidth(PW), .OPW(OPW), .TAG_W(TAG_W),
                        .DP_LATENCY(DPL), .OUT_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable[1]),
    .r_valid(r_valid[1]), .r_ready(r_ready[1]), .r_operands(r_operands[1]), .r_tag(r_tag[1]),
    .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_operands(b_operands[1]), .b_tag(b_tag[1]),
    .dp_operands(dp_operands[1]), .dp_rb(dp_rb[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_rb(out_rb[1]),
    .out_plane(out_plane[1]), .out_tag(out_tag[1]));

  function automatic logic [PW-1:0] dp_fn(input logic [OPW-1:0] x);
    return x[PW-1:0] ^ x[OPW-1 -: PW];
  endfunction

  // Two-stage datapath stand-in for each instance.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      dp_s1[k] <= dp_fn(dp_operands[k]);
      dp_rb[k] <= dp_s1[k];
    end
  end

  int checks = 0;
  int passed = 0;

  item_t            q[$];
  bit               prio_m;
  int               cyc = 0;
  int               n_pop, pop_cyc, n_gr_r, n_gr_b, obs_gr, tag_seq = 0;
  bit               obs_b_now;
  logic [PW-1:0]    pop_rb;
  logic             pop_plane;
  logic [TAG_W-1:0] pop_tag;
  bit               r_pend, b_pend;
  logic [OPW-1:0]   r_ops, b_ops;
  logic [TAG_W-1:0] r_tg, b_tg;
  int               r_rate, b_rate, r_budget, b_budget;

  // One clock cycle of stimulus against instance k, compared with the queue model.
  task automatic step(input int k, input bit en, input bit ordy);
    int depth;
    bit exp_ov, exp_pop, can, gr, gb;
    depth = (k == 0) ? 4 : 2;
    if (!r_pend && r_budget > 0 && $urandom_range(99) < r_rate) begin
      r_pend = 1'b1; r_ops = OPW'({$urandom(), $urandom()});
      r_tg = {4'hA, 12'(tag_seq)}; tag_seq++; r_budget--;
    end
    if (!b_pend && b_budget > 0 && $urandom_range(99) < b_rate) begin
      b_pend = 1'b1; b_ops = OPW'({$urandom(), $urandom()});
      b_tg = {4'hB, 12'(tag_seq)}; tag_seq++; b_budget--;
    end
    for (int j = 0; j < 2; j++) begin
      enable[j]     = (j == k) && en;
      r_valid[j]    = (j == k) && r_pend;
      b_valid[j]    = (j == k) && b_pend;
      out_ready[j]  = (j == k) && ordy;
      r_operands[j] = r_ops; r_tag[j] = r_tg;
      b_operands[j] = b_ops; b_tag[j] = b_tg;
    end
    #2;
    exp_ov  = (q.size() > 0) && (q[0].rdy <= cyc);
    exp_pop = exp_ov && ordy;
    can     = en && ((q.size() - int'(exp_pop)) < depth);
    gr      = can && r_pend && (!prio_m || !b_pend);
    gb      = can && b_pend && (prio_m || !r_pend);
    checks++;
    if (r_ready[k] !== gr) $display("FAIL r_ready inst=%0d cyc=%0d got=%b exp=%b", k, cyc, r_ready[k], gr);
    else passed++;
    checks++;
    if (b_ready[k] !== gb) $display("FAIL b_ready inst=%0d cyc=%0d got=%b exp=%b", k, cyc, b_ready[k], gb);
    else passed++;
    checks++;
    if (out_valid[k] !== exp_ov) $display("FAIL out_valid inst=%0d cyc=%0d got=%b exp=%b", k, cyc, out_valid[k], exp_ov);
    else passed++;
    if (exp_ov) begin
      checks++;
      if ({out_rb[k], out_plane[k], out_tag[k]} !== {q[0].rb, q[0].plane, q[0].tag})
        $display("FAIL out_data inst=%0d cyc=%0d got=%h/%b/%h exp=%h/%b/%h", k, cyc,
                 out_rb[k], out_plane[k], out_tag[k], q[0].rb, q[0].plane, q[0].tag);
      else passed++;
    end
    if (r_ready[k] === 1'b1 || b_ready[k] === 1'b1) obs_gr++;
    obs_b_now = (b_ready[k] === 1'b1);
    if (exp_pop) begin
      pop_rb = out_rb[k]; pop_plane = out_plane[k]; pop_tag = out_tag[k];
      pop_cyc = cyc; n_pop++;
      q.delete(0);
    end
    if (gr) begin
      q.push_back('{dp_fn(r_ops), 1'b0, r_tg, cyc + DPL + 2});
      prio_m = 1'b1; r_pend = 1'b0; n_gr_r++;
    end else if (gb) begin
      q.push_back('{dp_fn(b_ops), 1'b1, b_tg, cyc + DPL + 2});
      prio_m = 1'b0; b_pend = 1'b0; n_gr_b++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clear_model();
    q.delete();
    prio_m = 1'b0; r_pend = 1'b0; b_pend = 1'b0;
    r_rate = 0; b_rate = 0; r_budget = 0; b_budget = 0;
    n_pop = 0; n_gr_r = 0; n_gr_b = 0; obs_gr = 0;
    for (int j = 0; j < 2; j++) begin
      enable[j] = 1'b0; r_valid[j] = 1'b0; b_valid[j] = 1'b0; out_ready[j] = 1'b0;
      r_operands[j] = '0; b_operands[j] = '0; r_tag[j] = '0; b_tag[j] = '0;
    end
  endtask

  task automatic do_reset();
    clear_model();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_model();
    for (int j = 0; j < 2; j++) begin
      enable[j] = 1'b1; r_valid[j] = 1'b1; b_valid[j] = 1'b1;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0) $display("FAIL reset_out_valid inst=%0d got=%b exp=0", k, out_valid[k]);
      else passed++;
      checks++;
      if ({out_rb[k], out_plane[k], out_tag[k]} !== '0)
        $display("FAIL reset_out_data inst=%0d got=%h/%b/%h exp=0", k, out_rb[k], out_plane[k], out_tag[k]);
      else passed++;
      checks++;
      if (dp_operands[k] !== '0) $display("FAIL reset_dp_operands inst=%0d got=%h exp=0", k, dp_operands[k]);
      else passed++;
      checks++;
      if ({r_ready[k], b_ready[k]} !== 2'b00) $display("FAIL reset_ready inst=%0d got=%b%b exp=00", k, r_ready[k], b_ready[k]);
      else passed++;
    end
    do_reset();
  endtask

  task automatic test_single();
    int start;
    do_reset();
    r_pend = 1'b1;
    r_ops  = OPW'({12'h000, 32'($urandom()), 12'h7A5});
    r_tg   = 16'h0101;
    start  = cyc;
    repeat (9) step(0, 1'b1, 1'b1);
    checks++;
    if (n_pop !== 1) $display("FAIL single_count got=%0d exp=1", n_pop); else passed++;
    checks++;
    if ({pop_rb, pop_plane, pop_tag} !== {12'h7A5, 1'b0, 16'h0101})
      $display("FAIL single_result got=%h/%b/%h exp=7a5/0/0101", pop_rb, pop_plane, pop_tag);
    else passed++;
    checks++;
    if (pop_cyc - start !== 4) $display("FAIL single_latency got=%0d exp=4", pop_cyc - start); else passed++;
  endtask

  task automatic test_round_robin();
    int start;
    do_reset();
    r_rate = 100; b_rate = 100; r_budget = 8; b_budget = 8;
    start = cyc;
    for (int i = 0; i < 40 && n_pop < 16; i++) step(0, 1'b1, 1'b1);
    checks++;
    if (n_pop !== 16) $display("FAIL rr_count got=%0d exp=16", n_pop); else passed++;
    checks++;
    if (cyc - start !== 20) $display("FAIL rr_cycles got=%0d exp=20", cyc - start); else passed++;
    checks++;
    if (n_gr_r !== 8 || n_gr_b !== 8) $display("FAIL rr_split got=%0d/%0d exp=8/8", n_gr_r, n_gr_b); else passed++;
  endtask

  task automatic test_backpressure();
    int start;
    do_reset();
    r_rate = 100; r_budget = 12;
    repeat (10) step(0, 1'b1, 1'b0);
    checks++;
    if (obs_gr !== 4) $display("FAIL bp_grants got=%0d exp=4", obs_gr); else passed++;
    start = cyc;
    for (int i = 0; i < 60 && n_pop < 12; i++) step(0, 1'b1, 1'b1);
    checks++;
    if (n_pop !== 12) $display("FAIL bp_count got=%0d exp=12", n_pop); else passed++;
    checks++;
    if (cyc - start !== 12) $display("FAIL bp_gapless got=%0d exp=12", cyc - start); else passed++;
  endtask

  task automatic test_depth2();
    do_reset();
    r_rate = 100; r_budget = 10;
    repeat (4) step(1, 1'b1, 1'b1);
    checks++;
    if (obs_gr !== 2) $display("FAIL d2_throttle got=%0d exp=2", obs_gr); else passed++;
    for (int i = 0; i < 200 && n_pop < 10; i++) step(1, 1'b1, $urandom_range(3) != 0);
    checks++;
    if (n_pop !== 10) $display("FAIL d2_count got=%0d exp=10", n_pop); else passed++;
  endtask

  task automatic test_enable();
    do_reset();
    r_rate = 100; b_rate = 100; r_budget = 10; b_budget = 10;
    repeat (3) step(0, 1'b1, 1'b1);
    repeat (8) step(0, 1'b0, 1'b1);
    checks++;
    if (obs_gr !== 3) $display("FAIL en_no_grant got=%0d exp=3", obs_gr); else passed++;
    checks++;
    if (n_pop !== 3) $display("FAIL en_drained got=%0d exp=3", n_pop); else passed++;
    step(0, 1'b1, 1'b1);
    checks++;
    if (obs_b_now !== 1'b1) $display("FAIL en_resume_b got=%b exp=1", obs_b_now); else passed++;
    r_budget = 0; b_budget = 0;
    for (int i = 0; i < 60 && (q.size() > 0 || r_pend || b_pend); i++) step(0, 1'b1, 1'b1);
    checks++;
    if (q.size() !== 0) $display("FAIL en_final_drain got=%0d exp=0", q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int start;
    do_reset();
    r_rate = 100; r_budget = 10;
    repeat (5) step(0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) $display("FAIL rmid_out_valid got=%b exp=0", out_valid[0]); else passed++;
    checks++;
    if ({out_rb[0], out_plane[0], out_tag[0]} !== '0)
      $display("FAIL rmid_out_data got=%h/%b/%h exp=0", out_rb[0], out_plane[0], out_tag[0]);
    else passed++;
    checks++;
    if (dp_operands[0] !== '0) $display("FAIL rmid_dp_operands got=%h exp=0", dp_operands[0]); else passed++;
    checks++;
    if ({r_ready[0], b_ready[0]} !== 2'b00) $display("FAIL rmid_ready got=%b%b exp=00", r_ready[0], b_ready[0]);
    else passed++;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) step(0, 1'b1, 1'b1);
    r_pend = 1'b1; r_ops = OPW'({$urandom(), $urandom()}); r_tg = 16'h0C0D;
    start = cyc;
    repeat (7) step(0, 1'b1, 1'b1);
    checks++;
    if (n_pop !== 1 || pop_tag !== 16'h0C0D) $display("FAIL rmid_fresh got=%0d/%h exp=1/0c0d", n_pop, pop_tag);
    else passed++;
    checks++;
    if (pop_cyc - start !== 4) $display("FAIL rmid_latency got=%0d exp=4", pop_cyc - start); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_depth2();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
